// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample majority voting per bit, and a one-entry valid/ready output buffer.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk_100M,
  input  logic                 s_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int MID      = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [0:0]    LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 rx_d_q, rx_d_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [0:0]           stop_cnt_q, stop_cnt_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic decide;
  logic bit_val;
  logic ferr_now;
  logic frame_done;
  logic accept;

  assign rx_s    = sync2_q;
  assign decide  = (cnt_q == CNT_DEC);
  // Third vote is the live synchronised sample at the decision count.
  assign bit_val = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_d_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    ferr_now   = ferr_acc_q;
    frame_done = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      if (cnt_q == CNT_S0) s0_d = rx_s;
      if (cnt_q == CNT_S1) s1_d = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_d_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (decide) begin
          state_d   = bit_val ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_cnt_d = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          perr_acc_d = ((^shift_q) ^ bit_val) != PAR_ODD;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          ferr_now   = ferr_acc_q | ~bit_val;
          ferr_acc_d = ferr_now;
          if (stop_cnt_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = ferr_now ? ST_WAIT_HI : ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      // After a framing error, a stuck-low line must not be taken as a new start bit.
      ST_WAIT_HI: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output handshake: a word is transferred on every cycle where rx_valid and rx_ready are
  // both high; rx_data/rx_perr/rx_ferr are stable while rx_valid is high and not accepted.
  always_comb begin
    accept    = valid_q & rx_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    if (accept) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_now;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_100M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_d_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_d_q     <= rx_d_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_perr    = perr_q;
  assign rx_ferr    = ferr_q;
  assign rx_overrun = overrun_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule
